// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: operation codes and FSM states.
package mdu_pkg;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        DIV  = 2'b10,
        FIX  = 2'b11
    } mdu_state_e;

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration: shift-add multiply (right-shifting accumulator) or
// restoring divide (remainder in upper half, dividend/quotient in lower half).
module mdu_step
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 i_is_div,
    input  logic [2*WIDTH-1:0]   i_acc,
    input  logic [WIDTH-1:0]     i_opd,
    output logic [2*WIDTH-1:0]   o_acc,
    output logic                 o_qbit
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_shrem;
    logic [WIDTH:0] w_trial;

    assign w_sum   = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + (i_acc[0] ? {1'b0, i_opd} : '0);
    assign w_shrem = i_acc[2*WIDTH-1:WIDTH-1];
    assign w_trial = w_shrem - {1'b0, i_opd};

    // Quotient bit is reported separately; the divide accumulator leaves bit 0 clear for it.
    always_comb begin
        o_qbit = 1'b0;
        o_acc  = {w_sum, i_acc[WIDTH-1:1]};
        if (i_is_div) begin
            o_qbit = ~w_trial[WIDTH];
            o_acc  = {(o_qbit ? w_trial[WIDTH-1:0] : w_shrem[WIDTH-1:0]),
                      i_acc[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/mdu_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers, MTHI/MTLO and flush.
// Signed MULT/DIV are built only when MDU_SIGNED_EN is defined.
module mdu_unit
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    input  logic             flush,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int unsigned     CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    mdu_state_e         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opd;
    logic [WIDTH-1:0]   r_srca;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_is_div;
    logic               r_zero;
    logic               r_done;
    logic               r_div_zero;

    mdu_op_e            w_op;
    logic               w_start_div;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [2*WIDTH-1:0] w_step_acc;
    logic [2*WIDTH-1:0] w_acc_next;
    logic               w_qbit;
    logic [WIDTH-1:0]   w_res_hi;
    logic [WIDTH-1:0]   w_res_lo;

    assign w_op        = mdu_op_e'(op);
    assign w_start_div = (w_op == MDU_DIV) || (w_op == MDU_DIVU);

`ifdef MDU_SIGNED_EN
    logic r_neg_res;
    logic r_neg_rem;
    logic w_sgn_op;
    logic w_neg_a;
    logic w_neg_b;

    assign w_sgn_op = (w_op == MDU_MULT) || (w_op == MDU_DIV);
    assign w_neg_a  = w_sgn_op & srca[WIDTH-1];
    assign w_neg_b  = w_sgn_op & srcb[WIDTH-1];
    assign w_mag_a  = w_neg_a ? (~srca + 1'b1) : srca;
    assign w_mag_b  = w_neg_b ? (~srcb + 1'b1) : srcb;
`else
    assign w_mag_a  = srca;
    assign w_mag_b  = srcb;
`endif

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .i_is_div (r_is_div),
        .i_acc    (r_acc),
        .i_opd    (r_opd),
        .o_acc    (w_step_acc),
        .o_qbit   (w_qbit)
    );

    assign w_acc_next = w_step_acc | {{(2*WIDTH-1){1'b0}}, w_qbit};

    // Most-negative / -1 needs no special case: |MIN| negated wraps back to MIN.
    always_comb begin
        w_res_hi = r_acc[2*WIDTH-1:WIDTH];
        w_res_lo = r_acc[WIDTH-1:0];
`ifdef MDU_SIGNED_EN
        if (!r_is_div) begin
            if (r_neg_res) {w_res_hi, w_res_lo} = ~r_acc + 1'b1;
        end else begin
            if (r_neg_res) w_res_lo = ~r_acc[WIDTH-1:0] + 1'b1;
            if (r_neg_rem) w_res_hi = ~r_acc[2*WIDTH-1:WIDTH] + 1'b1;
        end
`endif
        if (r_is_div && r_zero) begin
            w_res_lo = '1;
            w_res_hi = r_srca;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_opd      <= '0;
            r_srca     <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_is_div   <= 1'b0;
            r_zero     <= 1'b0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
`ifdef MDU_SIGNED_EN
            r_neg_res  <= 1'b0;
            r_neg_rem  <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (hi_we) r_hi <= wdata;
                    if (lo_we) r_lo <= wdata;
                    if (start) begin
                        r_div_zero <= 1'b0;
                        r_is_div   <= w_start_div;
                        r_zero     <= w_start_div && (srcb == '0);
                        r_srca     <= srca;
                        r_cnt      <= '0;
                        r_acc      <= {{WIDTH{1'b0}}, (w_start_div ? w_mag_a : w_mag_b)};
                        r_opd      <= w_start_div ? w_mag_b : w_mag_a;
`ifdef MDU_SIGNED_EN
                        r_neg_res  <= w_neg_a ^ w_neg_b;
                        r_neg_rem  <= w_neg_a;
`endif
                        r_state    <= w_start_div ? DIV : MUL;
                    end
                end
                MUL, DIV: begin
                    if (flush) begin
                        r_state <= IDLE;
                    end else begin
                        r_acc <= w_acc_next;
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == LAST) r_state <= FIX;
                    end
                end
                FIX: begin
                    if (!flush) begin
                        r_hi       <= w_res_hi;
                        r_lo       <= w_res_lo;
                        r_done     <= 1'b1;
                        r_div_zero <= r_zero;
                    end
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign hi       = r_hi;
    assign lo       = r_lo;
    assign busy     = (r_state != IDLE);
    assign done     = r_done;
    assign div_zero = r_div_zero;

endmodule

// File: doc/mdu_unit.md
# mdu_unit

Parametrised iterative multiply/divide unit with architectural HI/LO registers, sitting beside the execute stage of the pipelined MIPS datapath. It accepts MULT/MULTU/DIV/DIVU from execute, runs a radix-2 shift-add / restoring-divide loop over WIDTH cycles, and holds `busy` so the hazard logic stalls MFHI/MFLO and further MDU ops. It also supports direct MTHI/MTLO writes and a pipeline flush that cancels an in-flight operation.

## Interface
- WIDTH, 32, operand and HI/LO width; also the iteration count (≥ 4, even).
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- start  in  1  launch operation; sampled only in IDLE.
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- srca  in  WIDTH  multiplicand / dividend (rs).
- srcb  in  WIDTH  multiplier / divisor (rt).
- hi_we  in  1  MTHI write enable.
- lo_we  in  1  MTLO write enable.
- wdata  in  WIDTH  MTHI/MTLO data.
- flush  in  1  cancel in-flight operation.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- busy  out  1  operation in progress (states MUL, DIV, FIX).
- done  out  1  one-cycle pulse; HI/LO just updated by an operation.
- div_zero  out  1  sticky flag, set by DIV/DIVU with srcb = 0, cleared by the next accepted start.

## Operation
- States: IDLE, MUL, DIV, FIX. Reset: state IDLE; hi, lo = 0; busy, done, div_zero = 0; counter = 0.
- IDLE + start: latch |srca|, |srcb| (signed ops) or raw values (unsigned ops); latch result-sign bits; counter = 0; go to MUL (op[1] = 0) or DIV (op[1] = 1).
- MUL: each cycle adds the shifted multiplicand if the current multiplier bit is set; 2·WIDTH-bit accumulator; counter++; after WIDTH cycles go to FIX.
- DIV: restoring step per cycle (shift the remainder in, trial-subtract, set the quotient bit); after WIDTH cycles go to FIX.
- FIX: apply sign correction (product negated if signs differ; quotient negated if signs differ; remainder takes the dividend's sign), write HI/LO, assert done, go to IDLE.
- MUL result: HI = upper WIDTH bits, LO = lower WIDTH bits. DIV result: LO = quotient, HI = remainder.
- Divide by zero: the loop still runs its full length; FIX writes LO = all ones and HI = srca (original, unsigned view), and sets div_zero.
- Signed overflow (most-negative / −1): LO = most-negative value, HI = 0; no flag.
- start outside IDLE is ignored; producers rely on busy.
- hi_we / lo_we are honoured only in IDLE and ignored while busy.
  - In IDLE with start in the same cycle, the write lands, and the operation later overwrites both registers.
- flush (any state except IDLE): next cycle state = IDLE, busy = 0, HI/LO unchanged, no done. Flush in IDLE has no effect. Flush has priority over FIX.
- Reset mid-operation: same as the reset values above, with HI/LO cleared.

## Timing
- start sampled at edge k: busy = 1 after edge k through edge k+WIDTH+1.
- FIX state occupies cycle k+WIDTH+1; HI/LO and done are visible after edge k+WIDTH+1. Total latency is WIDTH+1 cycles.
- A new start is accepted in the cycle after done (back-to-back throughput of WIDTH+2 cycles).
- hi_we / lo_we update HI/LO one edge after assertion.
- hi and lo are registered outputs; they are never combinational from inputs.

## Configuration
- MDU_SIGNED_EN defined: MULT and DIV perform signed arithmetic as above.
- MDU_SIGNED_EN undefined: sign-handling logic is removed; op[0] is ignored, so MULT behaves as MULTU and DIV as DIVU. The overflow special case does not exist.

## Structure
- Package mdu_pkg holds the op encoding enum (MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU) and the state enum (IDLE, MUL, DIV, FIX).
- mdu_unit contains the FSM, counter, HI/LO registers and sign correction.
- One combinational sub-module, mdu_step, computes a single multiply-or-divide iteration (accumulator/remainder next value and quotient bit), parametrised by WIDTH.

## Test plan
All scenarios use WIDTH = 32.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> after 33 cycles HI = 0xFFFFFFFE, LO = 0x00000001, done pulses once.
- MULT −3 × 7 -> HI = 0xFFFFFFFF, LO = 0xFFFFFFEB. DIV −7 / 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
  - Without MDU_SIGNED_EN: MULT 0xFFFFFFFD × 7 -> HI = 0x00000006, LO = 0xFFFFFFEB.
- DIVU 100 / 0 -> LO = 0xFFFFFFFF, HI = 0x00000064, div_zero = 1; a following DIVU 9 / 4 -> LO = 2, HI = 1, div_zero = 0.
- MTHI 0x1234 in IDLE, then MULTU 5 × 6 with flush asserted 10 cycles after start -> busy falls next cycle, HI = 0x1234, LO = 0, no done.
- start and lo_we held during busy -> both ignored; the single operation's result appears unchanged, and busy spans exactly 33 cycles.
- reset driven low 5 cycles into a DIV -> next edge HI = LO = 0, busy = 0, state IDLE; an immediately following MULTU 2 × 3 gives LO = 6.
